// File: rtl/eva_regfile_pkg.sv
// Shared types and constants for the EVA AHB-Lite register block.
package eva_regfile_pkg;

    // state | meaning
    // IDLE  | no data phase in progress, ready high
    // WAIT  | OKAY data phase, inserting wait states (ready low)
    // LAST  | final OKAY data-phase cycle; write commits / read data driven
    // ERR1  | first ERROR cycle (ready low)
    // ERR2  | second ERROR cycle (ready high), no new transfer accepted
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        LAST = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } state_e;

    // Word offsets within the 32-byte window (haddr[4:2])
    localparam logic [2:0] OFS_ID      = 3'd0;
    localparam logic [2:0] OFS_SCRATCH = 3'd1;
    localparam logic [2:0] OFS_CTRL    = 3'd2;
    localparam logic [2:0] OFS_LOAD    = 3'd3;
    localparam logic [2:0] OFS_COUNT   = 3'd4;
    localparam logic [2:0] OFS_STAT    = 3'd5;
    localparam logic [2:0] OFS_MASK    = 3'd6;
    localparam logic [2:0] OFS_SET     = 3'd7;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;

    // "EVA" is not expressible in hex digits; E7A0 stands in for it.
    localparam logic [31:0] ID_DEFAULT = 32'hE7A0_0001;

endpackage

// File: rtl/eva_regfile_timer.sv
// Down-counting timer: COUNT register, reload on terminal count, fire pulse.
module eva_regfile_timer (
    input  logic        hclk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_auto,
    input  logic        i_load_wr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_load_val,
    output logic [31:0] o_count,
    output logic        o_fire,
    output logic        o_en_clr
);

    logic [31:0] r_count;

    // A LOAD write pre-empts the terminal-count event in the same cycle.
    assign o_fire   = i_en & ~i_load_wr & (r_count == 32'd0);
    assign o_en_clr = o_fire & ~i_auto;
    assign o_count  = r_count;

    // COUNT: load on LOAD write, reload or hold at terminal count, else decrement while enabled
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            r_count <= 32'd0;
        end else if (i_load_wr) begin
            r_count <= i_wdata;
        end else if (o_fire) begin
            if (i_auto) begin
                r_count <= i_load_val;
            end
        end else if (i_en) begin
            r_count <= r_count - 32'd1;
        end
    end

endmodule

// File: rtl/eva_ahb_regfile.sv
// AHB-Lite slave register block: ID, scratch, timer control and interrupt registers.
module eva_ahb_regfile
    import eva_regfile_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = ID_DEFAULT,
    parameter int          NUM_IRQ     = 8
) (
    input  logic        hclk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata,
    output logic [31:0] intr
);

    localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e              r_state;
    logic [3:0]          r_wcnt;
    logic [2:0]          r_ofs;
    logic                r_wr;
    logic                r_hready_out;
    logic [1:0]          r_hresp;

    logic [31:0]         r_scratch;
    logic                r_ctrl_en;
    logic                r_ctrl_auto;
    logic [31:0]         r_load;
    logic [NUM_IRQ-1:0]  r_stat;
    logic [NUM_IRQ-1:0]  r_mask;

    logic                w_err;
    logic                w_accept;
    logic                w_commit;
    logic                w_load_wr;
    logic [31:0]         w_count;
    logic                w_fire;
    logic                w_en_clr;
    logic [NUM_IRQ-1:0]  w_stat_set;
    logic [NUM_IRQ-1:0]  w_stat_clr;
    logic [31:0]         w_rdata;
    logic [31:0]         w_intr;
    logic                w_unused;

    // htrans[0] only distinguishes SEQ from NONSEQ, which this slave treats alike.
    assign w_unused = &{1'b0, htrans[0]};

    assign w_err = (haddr[31:5] != BASE_ADDR[31:5]) | (haddr[1:0] != 2'b00) |
                   (hsize != HSIZE_WORD);

    // ERR2 is deliberately excluded: a transfer presented there is dropped.
    assign w_accept = hsel & htrans[1] & hready_in & ((r_state == IDLE) | (r_state == LAST));

    assign w_commit  = (r_state == LAST) & r_wr;
    assign w_load_wr = w_commit & (r_ofs == OFS_LOAD);

    assign hready_out = r_hready_out;
    assign hresp      = r_hresp;
    assign hrdata     = w_rdata;
    assign intr       = w_intr;

    // AHB data-phase sequencer with registered ready/response
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wcnt       <= 4'd0;
            r_ofs        <= 3'd0;
            r_wr         <= 1'b0;
            r_hready_out <= 1'b1;
            r_hresp      <= HRESP_OKAY;
        end else begin
            if (w_accept) begin
                r_ofs <= haddr[4:2];
                r_wr  <= hwrite;
            end
            case (r_state)
                IDLE, LAST: begin
                    if (w_accept && w_err) begin
                        r_state      <= ERR1;
                        r_hready_out <= 1'b0;
                        r_hresp      <= HRESP_ERROR;
                    end else if (w_accept && (WAIT_STATES > 0)) begin
                        r_state      <= WAIT;
                        r_wcnt       <= WCNT_INIT;
                        r_hready_out <= 1'b0;
                        r_hresp      <= HRESP_OKAY;
                    end else if (w_accept) begin
                        r_state      <= LAST;
                        r_hready_out <= 1'b1;
                        r_hresp      <= HRESP_OKAY;
                    end else begin
                        r_state      <= IDLE;
                        r_hready_out <= 1'b1;
                        r_hresp      <= HRESP_OKAY;
                    end
                end
                WAIT: begin
                    r_hresp <= HRESP_OKAY;
                    if (r_wcnt == 4'd0) begin
                        r_state      <= LAST;
                        r_hready_out <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                ERR1: begin
                    r_state      <= ERR2;
                    r_hready_out <= 1'b1;
                    r_hresp      <= HRESP_ERROR;
                end
                ERR2: begin
                    r_state      <= IDLE;
                    r_hready_out <= 1'b1;
                    r_hresp      <= HRESP_OKAY;
                end
                default: begin
                    r_state      <= IDLE;
                    r_hready_out <= 1'b1;
                    r_hresp      <= HRESP_OKAY;
                end
            endcase
        end
    end

    // STAT set/clear sources; hardware set wins over W1C on the same bit
    always_comb begin
        w_stat_set = '0;
        w_stat_clr = '0;
        if (w_commit && (r_ofs == OFS_SET)) begin
            w_stat_set = hwdata[NUM_IRQ-1:0];
        end
        if (w_fire) begin
            w_stat_set[0] = 1'b1;
        end
        if (w_commit && (r_ofs == OFS_STAT)) begin
            w_stat_clr = hwdata[NUM_IRQ-1:0];
        end
    end

    // Register file writes, committed at the end of the LAST cycle
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            r_scratch   <= 32'd0;
            r_ctrl_en   <= 1'b0;
            r_ctrl_auto <= 1'b0;
            r_load      <= 32'd0;
            r_stat      <= '0;
            r_mask      <= '0;
        end else begin
            if (w_commit && (r_ofs == OFS_SCRATCH)) begin
                r_scratch <= hwdata;
            end
            // A CTRL write in the same cycle as a one-shot fire keeps the written EN.
            if (w_commit && (r_ofs == OFS_CTRL)) begin
                r_ctrl_en   <= hwdata[CTRL_EN];
                r_ctrl_auto <= hwdata[CTRL_AUTO];
            end else if (w_en_clr) begin
                r_ctrl_en <= 1'b0;
            end
            if (w_load_wr) begin
                r_load <= hwdata;
            end
            if (w_commit && (r_ofs == OFS_MASK)) begin
                r_mask <= hwdata[NUM_IRQ-1:0];
            end
            r_stat <= (r_stat & ~w_stat_clr) | w_stat_set;
        end
    end

    // Read mux, driven only during the LAST cycle of a read
    always_comb begin
        w_rdata = '0;
        if ((r_state == LAST) && !r_wr) begin
            case (r_ofs)
                OFS_ID:      w_rdata = ID_VALUE;
                OFS_SCRATCH: w_rdata = r_scratch;
                OFS_CTRL: begin
                    w_rdata[CTRL_EN]   = r_ctrl_en;
                    w_rdata[CTRL_AUTO] = r_ctrl_auto;
                end
                OFS_LOAD:    w_rdata = r_load;
                OFS_COUNT:   w_rdata = w_count;
                OFS_STAT:    w_rdata[NUM_IRQ-1:0] = r_stat;
                OFS_MASK:    w_rdata[NUM_IRQ-1:0] = r_mask;
                default:     w_rdata = '0;
            endcase
        end
    end

    // Interrupt vector from registered STAT and MASK
    always_comb begin
        w_intr = '0;
        w_intr[NUM_IRQ-1:0] = r_stat & r_mask;
    end

    eva_regfile_timer u_timer (
        .hclk       (hclk),
        .rst_n      (rst_n),
        .i_en       (r_ctrl_en),
        .i_auto     (r_ctrl_auto),
        .i_load_wr  (w_load_wr),
        .i_wdata    (hwdata),
        .i_load_val (r_load),
        .o_count    (w_count),
        .o_fire     (w_fire),
        .o_en_clr   (w_en_clr)
    );

endmodule

// File: tb/tb_eva_ahb_regfile.sv
// Directed bench: u_dut_a runs with zero wait states, u_dut_b with two.
module tb_eva_ahb_regfile;
    import eva_regfile_pkg::*;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] ID_EXP = 32'hE7A0_0001;

    logic        hclk = 1'b0;
    logic        rst_n;
    logic        hsel_a, hsel_b;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        use_b;
    logic        w_hready;
    logic        hready_out_a, hready_out_b;
    logic [1:0]  hresp_a, hresp_b;
    logic [31:0] hrdata_a, hrdata_b, intr_a, intr_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 hclk = ~hclk;

    assign w_hready = use_b ? hready_out_b : hready_out_a;

    eva_ahb_regfile #(.WAIT_STATES(0)) u_dut_a (
        .hclk(hclk), .rst_n(rst_n), .hsel(hsel_a), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hready_in(w_hready),
        .hready_out(hready_out_a), .hresp(hresp_a), .hrdata(hrdata_a), .intr(intr_a)
    );

    eva_ahb_regfile #(.WAIT_STATES(2)) u_dut_b (
        .hclk(hclk), .rst_n(rst_n), .hsel(hsel_b), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hready_in(w_hready),
        .hready_out(hready_out_b), .hresp(hresp_b), .hrdata(hrdata_b), .intr(intr_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One non-pipelined transfer; returns one cycle after the completing edge.
    task automatic xfer(input bit on_b, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic [1:0] resp,
                        output int n_low, output int n_err);
        int guard;
        n_low = 0;
        n_err = 0;
        rdata = '0;
        resp  = 2'b00;
        guard = 0;
        use_b  = on_b;
        hsel_a = !on_b;
        hsel_b = on_b;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
        @(posedge hclk); #1;
        hsel_a = 1'b0;
        hsel_b = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hwdata = wdata;
        while (1) begin
            @(negedge hclk);
            if ((on_b ? hresp_b : hresp_a) == HRESP_ERROR) n_err++;
            if (!w_hready) begin
                n_low++;
                guard++;
                if (guard > 20) begin
                    check_val("xfer_timeout", 32'd0, 32'd1);
                    break;
                end
                @(posedge hclk); #1;
            end else begin
                rdata = on_b ? hrdata_b : hrdata_a;
                resp  = on_b ? hresp_b : hresp_a;
                break;
            end
        end
        @(posedge hclk); #1;
    endtask

    task automatic wr_reg(input bit on_b, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic [1:0]  rs;
        int nl, ne;
        xfer(on_b, 1'b1, addr, HSIZE_WORD, data, rd, rs, nl, ne);
        check_val("wr_resp", {30'd0, rs}, 32'd0);
    endtask

    task automatic rd_reg(input bit on_b, input logic [31:0] addr, output logic [31:0] data);
        logic [1:0] rs;
        int nl, ne;
        xfer(on_b, 1'b0, addr, HSIZE_WORD, 32'd0, data, rs, nl, ne);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int nl, ne;

        rst_n  = 1'b0;
        hsel_a = 1'b0;
        hsel_b = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'd0;
        hsize  = HSIZE_WORD;
        hwdata = 32'd0;
        use_b  = 1'b0;

        // reset
        repeat (3) @(posedge hclk);
        #1;
        check_val("rst_hready_a", {31'd0, hready_out_a}, 32'd1);
        check_val("rst_hresp_a", {30'd0, hresp_a}, 32'd0);
        check_val("rst_hrdata_a", hrdata_a, 32'd0);
        check_val("rst_intr_a", intr_a, 32'd0);
        check_val("rst_hready_b", {31'd0, hready_out_b}, 32'd1);
        check_val("rst_intr_b", intr_b, 32'd0);
        rst_n = 1'b1;
        @(posedge hclk); #1;

        xfer(1'b0, 1'b0, BASE, HSIZE_WORD, 32'd0, rd, rs, nl, ne);
        check_val("id_rdata", rd, ID_EXP);
        check_val("id_resp", {30'd0, rs}, 32'd0);

        // back-to-back on zero-wait slave: write 0x04<-5, read 0x04, read 0x10
        use_b  = 1'b0;
        hsel_a = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr  = BASE | 32'h04;
        hsize  = HSIZE_WORD;
        @(posedge hclk); #1;
        hwdata = 32'd5;
        hwrite = 1'b0;
        htrans = 2'b11;
        haddr  = BASE | 32'h04;
        @(negedge hclk);
        check_val("b2b_c1_rdy", {31'd0, hready_out_a}, 32'd1);
        @(posedge hclk); #1;
        haddr = BASE | 32'h10;
        @(negedge hclk);
        check_val("b2b_c2_rdy", {31'd0, hready_out_a}, 32'd1);
        check_val("b2b_raw_data", hrdata_a, 32'd5);
        check_val("b2b_c2_resp", {30'd0, hresp_a}, 32'd0);
        @(posedge hclk); #1;
        hsel_a = 1'b0;
        htrans = 2'b00;
        @(negedge hclk);
        check_val("b2b_c3_rdy", {31'd0, hready_out_a}, 32'd1);
        check_val("b2b_count", hrdata_a, 32'd0);
        @(posedge hclk); #1;

        // two wait states
        xfer(1'b1, 1'b1, BASE | 32'h04, HSIZE_WORD, 32'hDEAD_BEEF, rd, rs, nl, ne);
        check_val("ws2_wr_low", nl, 32'd2);
        check_val("ws2_wr_resp", {30'd0, rs}, 32'd0);
        xfer(1'b1, 1'b0, BASE | 32'h04, HSIZE_WORD, 32'd0, rd, rs, nl, ne);
        check_val("ws2_rd_low", nl, 32'd2);
        check_val("ws2_rd_data", rd, 32'hDEAD_BEEF);

        // error responses
        xfer(1'b1, 1'b0, BASE + 32'h20, HSIZE_WORD, 32'd0, rd, rs, nl, ne);
        check_val("err_range_resp", {30'd0, rs}, 32'd1);
        check_val("err_range_low", nl, 32'd1);
        check_val("err_range_cyc", ne, 32'd2);
        check_val("err_range_rdata", rd, 32'd0);
        xfer(1'b1, 1'b1, BASE + 32'h06, HSIZE_WORD, 32'h1234_5678, rd, rs, nl, ne);
        check_val("err_align_resp", {30'd0, rs}, 32'd1);
        check_val("err_align_low", nl, 32'd1);
        check_val("err_align_cyc", ne, 32'd2);
        xfer(1'b1, 1'b1, BASE | 32'h04, 3'b000, 32'h5555_5555, rd, rs, nl, ne);
        check_val("err_size_resp", {30'd0, rs}, 32'd1);
        check_val("err_size_low", nl, 32'd1);
        check_val("err_size_cyc", ne, 32'd2);
        rd_reg(1'b1, BASE | 32'h04, rd);
        check_val("err_scratch_kept", rd, 32'hDEAD_BEEF);

        // auto-reload timer: LOAD=3 fires every 4 cycles
        wr_reg(1'b0, BASE | 32'h18, 32'd1);
        wr_reg(1'b0, BASE | 32'h0C, 32'd3);
        wr_reg(1'b0, BASE | 32'h08, 32'd3);
        for (int i = 1; i <= 3; i++) begin
            @(posedge hclk); #1;
            check_val($sformatf("tmr_pre_%0d", i), intr_a, 32'd0);
        end
        @(posedge hclk); #1;
        check_val("tmr_fire1", intr_a, 32'd1);
        wr_reg(1'b0, BASE | 32'h14, 32'd1);
        check_val("tmr_w1c", intr_a, 32'd0);
        @(posedge hclk); #1;
        check_val("tmr_pre_fire2", intr_a, 32'd0);
        @(posedge hclk); #1;
        check_val("tmr_fire2", intr_a, 32'd1);
        repeat (2) @(posedge hclk);
        #1;
        wr_reg(1'b0, BASE | 32'h14, 32'd1);
        check_val("tmr_set_beats_w1c", intr_a, 32'd1);

        wr_reg(1'b0, BASE | 32'h08, 32'd0);
        wr_reg(1'b0, BASE | 32'h14, 32'hFF);
        check_val("tmr_stopped", intr_a, 32'd0);

        // one-shot: LOAD=2, CTRL=EN
        wr_reg(1'b0, BASE | 32'h0C, 32'd2);
        wr_reg(1'b0, BASE | 32'h08, 32'd1);
        repeat (2) @(posedge hclk);
        #1;
        check_val("os_pre_fire", intr_a, 32'd0);
        @(posedge hclk); #1;
        check_val("os_fire", intr_a, 32'd1);
        rd_reg(1'b0, BASE | 32'h08, rd);
        check_val("os_ctrl", rd, 32'd0);
        rd_reg(1'b0, BASE | 32'h10, rd);
        check_val("os_count", rd, 32'd0);
        wr_reg(1'b0, BASE | 32'h14, 32'd1);
        repeat (6) @(posedge hclk);
        #1;
        check_val("os_no_refire", intr_a, 32'd0);

        // SET and W1C on bit 7
        wr_reg(1'b0, BASE | 32'h18, 32'h80);
        wr_reg(1'b0, BASE | 32'h1C, 32'h80);
        check_val("set_intr", intr_a, 32'h80);
        rd_reg(1'b0, BASE | 32'h1C, rd);
        check_val("set_reads0", rd, 32'd0);
        rd_reg(1'b0, BASE | 32'h14, rd);
        check_val("stat_read", rd, 32'h80);
        wr_reg(1'b0, BASE | 32'h14, 32'h80);
        check_val("w1c_intr", intr_a, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
